uart_slave: RTL and testbench

Memory-mapped UART peripheral behind the system address decoder, selected for 0xfa00..0xfa0f. Only the low address bit is decoded: 0 = status/control, 1 = rx/tx data. It contains an 8N1 transmitter with a 1-byte holding register, an 8N1 receiver with an RX FIFO, a level interrupt, and a break-detect reset request.

---
 rtl/uart_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART: status/control at addr 0, data at addr 1. It has a
// transmit holding register, a receive FIFO, a level interrupt and a break-triggered reset request.
module uart_slave #(
    parameter int CLKS_PER_BIT  = 217,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int BREAK_BITS    = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_cs,
    input  logic       i_we,
    output logic       o_ack,
    output logic       o_int,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_reset
);
    localparam int CW      = $clog2(CLKS_PER_BIT);
    localparam int AW      = $clog2(RX_FIFO_DEPTH);
    localparam int BRK_MAX = BREAK_BITS * CLKS_PER_BIT;
    localparam int BW      = $clog2(BRK_MAX + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BRK_TOP   = BW'(BRK_MAX);
    localparam logic [BW-1:0] BRK_ARM   = BW'(BRK_MAX - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic          cs_q;
    logic          int_en_q, int_en_d;
    logic          overrun_q, overrun_d;
    logic          int_q, int_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          rx_meta_q, rx_s_q;
    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BW-1:0] brk_cnt_q, brk_cnt_d;
    logic          brk_armed_q, brk_armed_d;
    logic          reset_q, reset_d;
    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];

    logic strobe, rd_stb, wr_stb;
    logic rx_avail, fifo_full, push_req, push, pop, ovf_set;
    logic tx_tick, tx_load, rx_tick, rx_half, brk_hold;
    logic [7:0] status;

    // Side effects fire once on the rising edge of the select, however long it is held.
    assign strobe = i_cs & ~cs_q;
    assign rd_stb = strobe & ~i_we;
    assign wr_stb = strobe & i_we;
    assign o_ack  = i_cs;

    assign rx_avail  = (wr_ptr_q != rd_ptr_q);
    assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = rd_stb & i_addr & rx_avail;
    assign push      = push_req & (~fifo_full | pop);
    assign ovf_set   = push_req & fifo_full & ~pop;

    assign status = {3'b000, int_en_q, (tx_state_q != ST_IDLE), overrun_q, ~hold_full_q, rx_avail};
    assign o_dat  = i_addr ? (rx_avail ? fifo_mem[rd_ptr_q[AW-1:0]] : 8'h00) : status;

    assign o_int   = int_q;
    assign o_tx    = tx_q;
    assign o_reset = reset_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cs_q        <= 1'b0;
            int_en_q    <= 1'b0;
            overrun_q   <= 1'b0;
            int_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            brk_cnt_q   <= '0;
            brk_armed_q <= 1'b1;
            reset_q     <= 1'b0;
        end else begin
            cs_q        <= i_cs;
            int_en_q    <= int_en_d;
            overrun_q   <= overrun_d;
            int_q       <= int_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_meta_q   <= i_rx;
            rx_s_q      <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            brk_cnt_q   <= brk_cnt_d;
            brk_armed_q <= brk_armed_d;
            reset_q     <= reset_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && push)
            fifo_mem[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    always_comb begin
        int_en_d    = int_en_q;
        overrun_d   = overrun_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (wr_stb && !i_addr)
            int_en_d = i_dat[0];
        if (rd_stb && !i_addr)
            overrun_d = 1'b0;
        if (ovf_set)
            overrun_d = 1'b1;
        if (tx_load)
            hold_full_d = 1'b0;
        if (wr_stb && i_addr && !hold_full_q) begin
            hold_d      = i_dat;
            hold_full_d = 1'b1;
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        int_d    = int_en_q & rx_avail;
    end

    assign tx_tick = (tx_cnt_q == BIT_LAST);
    assign tx_load = hold_full_q && ((tx_state_q == ST_IDLE) || (tx_state_q == ST_STOP && tx_tick));

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            ST_IDLE:  if (hold_full_q) tx_state_d = ST_START;
            ST_START: if (tx_tick) tx_state_d = ST_DATA;
            ST_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = ST_STOP;
            ST_STOP:  if (tx_tick) tx_state_d = hold_full_q ? ST_START : ST_IDLE;
            default:  tx_state_d = ST_IDLE;
        endcase
    end

    // The line level is registered from the next state so o_tx never glitches.
    always_comb begin
        tx_cnt_d   = (tx_state_q == ST_IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_load) begin
            tx_shift_d = hold_q;
            tx_bit_d   = '0;
        end else if (tx_state_q == ST_DATA && tx_tick) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
        end
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign rx_tick  = (rx_cnt_q == BIT_LAST);
    assign rx_half  = (rx_cnt_q == HALF_LAST);
    // A saturated break counter holds the receiver idle so a released break cannot complete a bogus frame.
    assign brk_hold = (brk_cnt_q == BRK_TOP);

    always_comb begin
        rx_state_d = rx_state_q;
        if (brk_hold) begin
            rx_state_d = ST_IDLE;
        end else begin
            case (rx_state_q)
                ST_IDLE:  if (!rx_s_q) rx_state_d = ST_START;
                ST_START: if (rx_half) rx_state_d = rx_s_q ? ST_IDLE : ST_DATA;
                ST_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                ST_STOP:  if (rx_tick) rx_state_d = ST_IDLE;
                default:  rx_state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push_req   = 1'b0;
        if (rx_state_d != rx_state_q || rx_state_q == ST_IDLE || rx_tick)
            rx_cnt_d = '0;
        if (rx_state_q == ST_START)
            rx_bit_d = '0;
        if (rx_state_q == ST_DATA && rx_tick) begin
            rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 1'b1;
        end
        if (rx_state_q == ST_STOP && rx_tick && rx_s_q && !brk_hold)
            push_req = 1'b1;

        brk_cnt_d   = rx_s_q ? '0 : (brk_hold ? brk_cnt_q : brk_cnt_q + 1'b1);
        reset_d     = brk_armed_q && !rx_s_q && (brk_cnt_q == BRK_ARM);
        brk_armed_d = rx_s_q ? 1'b1 : (reset_d ? 1'b0 : brk_armed_q);
    end
endmodule

// File: tb/tb_uart_slave.sv
// Bench for uart_slave: directed and randomized bus/serial traffic checked
// against a queue-based model of the peripheral's visible behaviour.
module tb_uart_slave;
    localparam int CPB     = 4;
    localparam int DEPTH   = 4;
    localparam int BRK     = 20;
    localparam int FW      = 10 * CPB;
    localparam int INT_LAT = 2 + 1 + CPB / 2 + 9 * CPB + 1;
    localparam int BRK_LAT = BRK * CPB + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       addr = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dat_in = 8'h00;
    logic [7:0] dat_out;
    logic       ack, irq, tx, sys_rst;

    uart_slave #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH), .BREAK_BITS(BRK)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_addr(addr), .i_dat(dat_in), .o_dat(dat_out),
        .i_cs(cs), .i_we(we), .o_ack(ack), .o_int(irq), .i_rx(rx), .o_tx(tx), .o_reset(sys_rst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] m_q[$];
    bit m_ovf = 1'b0;
    bit m_int_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {3'b000, m_int_en, 1'b0, m_ovf, 1'b1, (m_q.size() != 0)};
    endfunction

    function automatic logic [FW-1:0] frame_wave(input logic [7:0] b);
        logic [9:0] fb;
        logic [FW-1:0] w;
        fb = {1'b1, b, 1'b0};
        for (int c = 0; c < FW; c++) w[c] = fb[c / CPB];
        return w;
    endfunction

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b1; cs = 1'b1; dat_in = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        if (!a) m_int_en = d[0];
    endtask

    task automatic bus_read(input logic a, input int hold, output logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b0; cs = 1'b1;
        #1;
        d = dat_out;
        chk("ack", ack, 1'b1);
        repeat (hold) @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic status_check(input string tag);
        logic [7:0] d;
        bus_read(1'b0, 1, d);
        chk(tag, d, exp_status());
        m_ovf = 1'b0;
    endtask

    task automatic data_check(input string tag, input int hold);
        logic [7:0] d, e;
        e = (m_q.size() != 0) ? m_q[0] : 8'h00;
        bus_read(1'b1, hold, d);
        chk(tag, d, e);
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic rx_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop_ok);
        rx_bit(1'b1);
        if (stop_ok) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    // Two writes go out back to back; the third lands while the holding register is full.
    task automatic tx_check3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        fork
            begin
                logic [FW-1:0] cap;
                int w, lows;
                w = 0;
                @(negedge clk);
                while (tx !== 1'b0 && w < 60) begin
                    @(negedge clk);
                    w++;
                end
                chk("tx_start_seen", (w < 60), 1'b1);
                for (int f = 0; f < 2; f++) begin
                    for (int c = 0; c < FW; c++) begin
                        cap[c] = tx;
                        @(negedge clk);
                    end
                    chk(f == 0 ? "tx_frame0" : "tx_frame1", cap, frame_wave(f == 0 ? b0 : b1));
                end
                lows = 0;
                for (int c = 0; c < FW; c++) begin
                    if (tx !== 1'b1) lows++;
                    @(negedge clk);
                end
                chk("tx_third_dropped", lows, 0);
            end
            begin
                logic [7:0] d;
                bus_write(1'b1, b0);
                bus_write(1'b1, b1);
                bus_read(1'b0, 1, d);
                chk("tx_status_full", d, exp_status() & 8'hFD | 8'h08);
                bus_write(1'b1, b2);
            end
        join
    endtask

    task automatic break_run(input string tag);
        int first, cnt;
        first = -1;
        cnt = 0;
        @(negedge clk);
        rx = 1'b0;
        for (int n = 1; n <= BRK_LAT + 30; n++) begin
            @(negedge clk);
            if (sys_rst === 1'b1) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        chk({tag, "_pulses"}, cnt, 1);
        chk({tag, "_cycle"}, first, BRK_LAT);
        rx = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (sys_rst !== 1'b0) cnt++;
        end
        chk({tag, "_quiet_after"}, cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int first, lows;
        logic [7:0] rb [5];

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_int", irq, 1'b0);
        chk("rst_reset_out", sys_rst, 1'b0);
        status_check("rst_status");

        tx_check3(8'hA5, 8'h3C, 8'h77);
        status_check("tx_idle_status");

        send_frame(8'h5A, 1'b1);
        send_frame(8'h81, 1'b1);
        status_check("rx2_status");
        data_check("rx2_byte0", 1);
        data_check("rx2_byte1", 1);
        status_check("rx2_empty_status");

        send_frame(8'hC3, 1'b1);
        send_frame(8'h19, 1'b1);
        data_check("hold_cs_read", 3);
        data_check("hold_cs_next", 1);
        data_check("hold_cs_empty", 1);

        for (int i = 0; i < 5; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            send_frame(rb[i], 1'b1);
        end
        status_check("ovf_status_set");
        for (int i = 0; i < DEPTH; i++) data_check("ovf_read", 1);
        status_check("ovf_status_cleared");

        bus_write(1'b0, 8'h01);
        first = -1;
        fork
            send_frame(8'h6E, 1'b1);
            begin
                @(negedge clk);
                for (int n = 1; n <= 60; n++) begin
                    @(negedge clk);
                    if (irq === 1'b1 && first < 0) first = n;
                end
            end
        join
        chk("int_rise_cycle", first, INT_LAT);
        status_check("int_status");
        chk("int_level", irq, 1'b1);
        data_check("int_byte", 1);
        @(negedge clk);
        chk("int_dropped", irq, 1'b0);
        bus_write(1'b0, 8'h00);

        break_run("break1");
        break_run("break2");
        status_check("break_no_push_status");
        data_check("break_no_push_data", 1);

        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        status_check("glitch_status");
        data_check("glitch_data", 1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
            status_check("rand_status");
            for (int i = 0; i < 3; i++) data_check("rand_byte", 1);
        end

        tx_check3(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        send_frame(8'hE7, 1'b1);
        bus_write(1'b1, 8'h00);
        repeat (12) @(negedge clk);
        chk("midrst_tx_busy", tx, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_tx_idle", tx, 1'b1);
        m_q.delete();
        m_ovf = 1'b0;
        m_int_en = 1'b0;
        status_check("midrst_status");
        data_check("midrst_data", 1);
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("midrst_tx_quiet", lows, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
